// File: rtl/seq_multiplier_32_bit.sv
// Unsigned shift-and-add multiplier: one partial product per cycle, WIDTH iterations.
// The low product word feeds the ALU result mux and the high word feeds the HI register.
module seq_multiplier_32_bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product,
  output logic [1:0]         o_dbg_state
);

  // Handshake: start is sampled only in IDLE, and A/B are captured on that same edge.
  // busy is high in LOAD and CALC. done pulses for one cycle, and Product is valid
  // from that cycle until the next done or reset. A start seen while busy or done is dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH:0]     w_upper;
  logic [2*WIDTH:0]   w_acc_shift;
  logic               w_last;

  // The upper half is WIDTH+1 bits wide, so the carry out of the add survives the shift.
  assign w_upper     = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_shift = {1'b0, w_upper, r_acc[WIDTH-1:1]};
  assign w_last      = (r_cnt == LAST_CNT);

  assign Product     = r_product;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= A;
            r_acc   <= {1'b0, {WIDTH{1'b0}}, B};
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
        end
        S_CALC: begin
          r_acc <= w_acc_shift;
          r_cnt <= r_cnt + 1'b1;
          // Register the product on the way into DONE so it is visible during the done pulse.
          if (w_last) r_product <= w_acc_shift[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_32_bit.sv
// Directed bench for seq_multiplier_32_bit: expected products are queued at issue time
// and popped when done pulses. Latency, busy/done exclusivity and Product holding are checked.
module tb_seq_multiplier_32_bit;
  localparam int W   = 32;
  localparam int LAT = 34;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] Product;
  logic [1:0]     dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  seq_multiplier_32_bit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Product     (Product),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // driver: one start pulse, with the operands scrambled right after acceptance
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    A     = $urandom();
    B     = $urandom();
  endtask

  // Waits for done, starting from the negedge after the sampling edge.
  // inj_at > 0 pulses an extra start at that cycle, which the DUT must ignore.
  task automatic wait_done(input string tag, input int inj_at);
    int lat;
    logic [63:0] held;
    logic [63:0] exp;
    lat  = 1;
    held = Product;
    while (done !== 1'b1 && lat < 200) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      check({tag, "_hold"}, Product, held);
      if (inj_at > 0 && lat == inj_at) begin
        start = 1'b1;
        A     = 32'd2;
        B     = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_product"}, Product, exp);
    end
    held = Product;
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_product_kept"}, Product, held);
  endtask

  initial begin
    int extra;
    int pulses;
    int cyc;
    int last_done;
    logic [63:0] held;
    logic [63:0] exp;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    @(negedge clk);
    check("rst_product", Product, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    start_op(32'd3, 32'd5, 1'b1);
    wait_done("op_3x5", 0);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("op_max", 0);

    start_op(32'h1234_5678, 32'd0, 1'b1);
    wait_done("op_b0", 0);
    start_op(32'd0, 32'h8000_0001, 1'b1);
    wait_done("op_a0", 0);

    start_op(32'd7, 32'd9, 1'b1);
    wait_done("op_ignore", 9);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("ignore_no_second_done", 64'(extra), 64'd0);

    for (int i = 0; i < 3; i++) begin
      start_op($urandom(), $urandom(), 1'b1);
      wait_done("op_rand", 0);
    end

    // abort: reset mid-operation must clear outputs without a clock edge
    start_op(32'd3, 32'd5, 1'b1);
    wait_done("op_3x5_pre", 0);
    start_op(32'd100, 32'd200, 1'b0);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_product", Product, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("abort_no_done", 64'(extra), 64'd0);
    check("abort_product_after", Product, 64'd0);
    start_op(32'd100, 32'd200, 1'b1);
    wait_done("op_after_abort", 0);

    // back-to-back with start held high
    @(negedge clk);
    A     = 32'h0001_0000;
    B     = 32'h0001_0000;
    start = 1'b1;
    repeat (3) exp_q.push_back(model(32'h0001_0000, 32'h0001_0000));
    held      = 64'd20000;
    pulses    = 0;
    cyc       = 0;
    last_done = 0;
    while (pulses < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      check("b2b_exclusive", {63'd0, busy & done}, 64'd0);
      if (done === 1'b1) begin
        pulses++;
        if (pulses > 1) check("b2b_interval", 64'(cyc - last_done), 64'd35);
        last_done = cyc;
        exp = exp_q.pop_front();
        check("b2b_product", Product, exp);
        held = exp;
        if (pulses == 3) start = 1'b0;
      end else begin
        check("b2b_hold", Product, held);
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd3);
    repeat (2) @(negedge clk);
    check("b2b_idle_after", {63'd0, busy}, 64'd0);
    check("b2b_product_final", Product, 64'h0000_0001_0000_0000);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
